// File: rtl/bsg_mul_sched_pkg.sv
// Shared types and constants for the iterative multiplier scheduler.
package bsg_mul_sched_pkg;

  typedef enum logic [1:0] {
    eIdle = 2'd0,
    eBusy = 2'd1,
    eResp = 2'd2
  } state_e;

  localparam int ops_cnt_width_lp = 32;

endpackage

// File: rtl/bsg_mul_sched_rr_arb.sv
// Round-robin arbiter: the requester at pointer has highest priority, then
// priority wraps upward modulo num_req_p. Grant is one-hot or all-zero.
module bsg_mul_sched_rr_arb #(
  parameter int num_req_p = 4,
  localparam int idx_w_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] reqs,
  input  logic                 enable,
  input  logic [idx_w_lp-1:0]  pointer,
  output logic [num_req_p-1:0] grant
);

  logic                found;
  logic [idx_w_lp-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = idx_w_lp'((int'(pointer) + i) % num_req_p);
      if (enable && !found && reqs[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_mul_iterative_scheduler.sv
// Shares one iterative multiplier among num_req_p requesters, one operation
// in flight at a time, with round-robin grant and per-owner response return.
module bsg_mul_iterative_scheduler
  import bsg_mul_sched_pkg::*;
#(
  parameter int num_req_p = 4,
  parameter int width_p   = 64
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p-1:0][width_p-1:0]   req_opA_i,
  input  logic [num_req_p-1:0][width_p-1:0]   req_opB_i,
  input  logic [num_req_p-1:0]                req_signed_i,
  output logic [num_req_p-1:0]                req_ready_o,
  input  logic                                mul_ready_i,
  output logic                                mul_v_o,
  output logic [width_p-1:0]                  mul_opA_o,
  output logic [width_p-1:0]                  mul_opB_o,
  output logic                                mul_signed_o,
  input  logic                                mul_v_i,
  input  logic [2*width_p-1:0]                mul_result_i,
  output logic                                mul_yumi_o,
  output logic [num_req_p-1:0]                resp_v_o,
  output logic [2*width_p-1:0]                resp_data_o,
  input  logic [num_req_p-1:0]                resp_yumi_i,
  output logic [ops_cnt_width_lp-1:0]         ops_done_o
);

  localparam int idx_w_lp = $clog2(num_req_p);
  typedef logic [idx_w_lp-1:0] idx_t;

  state_e                      state_r, state_n;
  idx_t                        last_grant_r, owner_r, pointer, grant_idx;
  logic [2*width_p-1:0]        result_r;
  logic [ops_cnt_width_lp-1:0] ops_done_r;
  logic [num_req_p-1:0]        grant;
  logic                        arb_en, resp_accept;

  assign pointer = (last_grant_r == idx_t'(num_req_p - 1)) ? '0 : last_grant_r + idx_t'(1);
  // Reset gating keeps the grant low while state is already forced to eIdle.
  assign arb_en  = (state_r == eIdle) & mul_ready_i & ~reset_i;

  bsg_mul_sched_rr_arb #(.num_req_p(num_req_p)) arb (
    .reqs    (req_v_i),
    .enable  (arb_en),
    .pointer (pointer),
    .grant   (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant[i]) grant_idx = idx_t'(i);
    end
  end

  assign req_ready_o  = grant;
  assign mul_v_o      = |grant;
  assign mul_opA_o    = req_opA_i[grant_idx];
  assign mul_opB_o    = req_opB_i[grant_idx];
  assign mul_signed_o = req_signed_i[grant_idx];

  assign mul_yumi_o   = (state_r == eBusy) & mul_v_i;
  assign resp_accept  = (state_r == eResp) & resp_yumi_i[owner_r];
  assign resp_v_o     = (state_r == eResp) ? ({{(num_req_p-1){1'b0}}, 1'b1} << owner_r) : '0;
  assign resp_data_o  = result_r;
  assign ops_done_o   = ops_done_r;

  always_comb begin
    state_n = state_r;
    case (state_r)
      eIdle:   if (mul_v_o)     state_n = eBusy;
      eBusy:   if (mul_v_i)     state_n = eResp;
      eResp:   if (resp_accept) state_n = eIdle;
      default:                  state_n = eIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= eIdle;
      last_grant_r <= idx_t'(num_req_p - 1);
      owner_r      <= '0;
      result_r     <= '0;
      ops_done_r   <= '0;
    end else begin
      state_r <= state_n;
      if (mul_v_o) begin
        owner_r      <= grant_idx;
        last_grant_r <= grant_idx;
      end
      if (mul_yumi_o)  result_r   <= mul_result_i;
      if (resp_accept) ops_done_r <= ops_done_r + 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_mul_iterative_scheduler.sv
// Directed and randomized bench for the scheduler with a fixed-latency multiplier.
module tb_bsg_mul_iterative_scheduler;
  localparam int N   = 4;
  localparam int W   = 64;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [N-1:0]      req_v_i;
  logic [N-1:0][W-1:0] req_opA_i, req_opB_i;
  logic [N-1:0]      req_signed_i;
  logic [N-1:0]      req_ready_o;
  logic              mul_ready_i, mul_v_o, mul_signed_o, mul_v_i, mul_yumi_o;
  logic [W-1:0]      mul_opA_o, mul_opB_o;
  logic [2*W-1:0]    mul_result_i;
  logic [N-1:0]      resp_v_o, resp_yumi_i;
  logic [2*W-1:0]    resp_data_o;
  logic [31:0]       ops_done_o;

  logic              mul_rdy_en, mul_busy;
  int                mul_cnt;
  logic [2*W-1:0]    mul_prod;

  int errors = 0, checks = 0;
  int last_g, ops_exp, wc;
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  logic         sgn [N];
  int           grants [N];
  int           order_q [$];
  logic [2*W-1:0] last_data;

  always #5 clk = ~clk;

  bsg_mul_iterative_scheduler #(.num_req_p(N), .width_p(W)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i), .req_opA_i(req_opA_i),
    .req_opB_i(req_opB_i), .req_signed_i(req_signed_i), .req_ready_o(req_ready_o),
    .mul_ready_i(mul_ready_i), .mul_v_o(mul_v_o), .mul_opA_o(mul_opA_o),
    .mul_opB_o(mul_opB_o), .mul_signed_o(mul_signed_o), .mul_v_i(mul_v_i),
    .mul_result_i(mul_result_i), .mul_yumi_o(mul_yumi_o), .resp_v_o(resp_v_o),
    .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i), .ops_done_o(ops_done_o)
  );

  function automatic logic [2*W-1:0] prod_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    if (s) return sa * sb;
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Fixed-latency multiplier: result valid LAT cycles after issue, held until yumi.
  assign mul_ready_i  = mul_rdy_en & ~mul_busy;
  assign mul_v_i      = mul_busy && (mul_cnt == 0);
  assign mul_result_i = mul_v_i ? mul_prod : '0;

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      mul_busy <= 1'b0;
      mul_cnt  <= 0;
      mul_prod <= '0;
    end else if (mul_v_o && mul_ready_i) begin
      mul_busy <= 1'b1;
      mul_cnt  <= LAT - 1;
      mul_prod <= prod_f(mul_opA_o, mul_opB_o, mul_signed_o);
    end else if (mul_busy) begin
      if (mul_cnt != 0) mul_cnt <= mul_cnt - 1;
      else if (mul_yumi_o) mul_busy <= 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      opa[i] = {$urandom, $urandom};
      opb[i] = {$urandom, $urandom};
      sgn[i] = 1'($urandom);
    end
  endtask

  // One full transaction: wait for grant, check issue, latency, hold, accept.
  task automatic do_op(input logic [N-1:0] active, input int bp, output int wait_c);
    int g;
    logic [N-1:0] oh;
    logic [2*W-1:0] expd, held;
    req_v_i = active;
    for (int i = 0; i < N; i++) begin
      req_opA_i[i] = opa[i];
      req_opB_i[i] = opb[i];
      req_signed_i[i] = sgn[i];
    end
    #1;
    wait_c = 0;
    while (mul_v_o !== 1'b1 && wait_c < 40) begin
      step();
      #1;
      wait_c++;
    end
    chk("grant_seen", 128'(mul_v_o), 128'(1));
    if (mul_v_o !== 1'b1) begin
      req_v_i = '0;
      return;
    end
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (last_g + 1 + k) % N;
      if (g < 0 && active[idx]) g = idx;
    end
    oh = '0;
    oh[g] = 1'b1;
    chk("req_ready_grant", 128'(req_ready_o), 128'(oh));
    chk("mul_opA", 128'(mul_opA_o), 128'(opa[g]));
    chk("mul_opB", 128'(mul_opB_o), 128'(opb[g]));
    chk("mul_signed", 128'(mul_signed_o), 128'(sgn[g]));
    expd = prod_f(opa[g], opb[g], sgn[g]);
    last_g = g;
    grants[g]++;
    order_q.push_back(g);
    step();
    for (int c = 1; c <= LAT; c++) begin
      chk("resp_v_early", 128'(resp_v_o), 128'(0));
      chk("req_ready_busy", 128'(req_ready_o), 128'(0));
      step();
    end
    chk("resp_v_owner", 128'(resp_v_o), 128'(oh));
    chk("resp_data", resp_data_o, expd);
    held = resp_data_o;
    last_data = resp_data_o;
    for (int b = 0; b < bp; b++) begin
      resp_yumi_i = N'($urandom) & ~oh;
      step();
      chk("bp_resp_v", 128'(resp_v_o), 128'(oh));
      chk("bp_resp_data", resp_data_o, held);
      chk("bp_req_ready", 128'(req_ready_o), 128'(0));
      chk("bp_mul_v", 128'(mul_v_o), 128'(0));
    end
    resp_yumi_i = oh | (N'($urandom) & ~oh);
    #1;
    chk("no_grant_on_accept", 128'(req_ready_o), 128'(0));
    step();
    resp_yumi_i = '0;
    ops_exp++;
    chk("ops_done", 128'(ops_done_o), 128'(ops_exp));
    chk("resp_v_cleared", 128'(resp_v_o), 128'(0));
    req_v_i = '0;
  endtask

  task automatic model_reset();
    last_g  = N - 1;
    ops_exp = 0;
    for (int i = 0; i < N; i++) grants[i] = 0;
    order_q.delete();
  endtask

  initial begin
    reset_i      = 1'b1;
    req_v_i      = '1;
    req_opA_i    = '0;
    req_opB_i    = '0;
    req_signed_i = '0;
    resp_yumi_i  = '0;
    mul_rdy_en   = 1'b1;
    model_reset();
    step();
    step();
    #1;
    chk("rst_req_ready", 128'(req_ready_o), 128'(0));
    chk("rst_mul_v", 128'(mul_v_o), 128'(0));
    chk("rst_mul_yumi", 128'(mul_yumi_o), 128'(0));
    chk("rst_resp_v", 128'(resp_v_o), 128'(0));
    chk("rst_ops_done", 128'(ops_done_o), 128'(0));
    chk("rst_resp_data", resp_data_o, 128'(0));
    reset_i = 1'b0;
    req_v_i = '0;

    // Single unsigned request from requester 2.
    randomize_ops();
    opa[2] = 64'd3; opb[2] = 64'd5; sgn[2] = 1'b0;
    do_op(4'b0100, 0, wc);
    chk("single_data", last_data, 128'd15);
    chk("single_ops_done", 128'(ops_done_o), 128'd1);

    // Signed request from requester 0.
    opa[0] = -64'sd2; opb[0] = 64'd3; sgn[0] = 1'b1;
    do_op(4'b0001, 0, wc);
    chk("signed_data", last_data, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA);

    // Multiplier not ready: no grant until it rises, then grant that cycle.
    randomize_ops();
    mul_rdy_en = 1'b0;
    req_v_i = '1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mulrdy0_req_ready", 128'(req_ready_o), 128'(0));
      chk("mulrdy0_mul_v", 128'(mul_v_o), 128'(0));
      step();
    end
    mul_rdy_en = 1'b1;
    do_op('1, 0, wc);
    chk("mulrdy_same_cycle", 128'(wc), 128'(0));

    // Response backpressure for 20 cycles with other requesters pending.
    randomize_ops();
    do_op(4'b1011, 20, wc);

    // Lone requester is granted on every idle cycle.
    for (int i = 0; i < 3; i++) begin
      randomize_ops();
      do_op(4'b0010, 0, wc);
      chk("lone_no_wait", 128'(wc), 128'(0));
    end

    // Randomized traffic with optional multiplier stalls.
    for (int i = 0; i < 12; i++) begin
      randomize_ops();
      if ($urandom_range(0, 3) == 0) begin
        mul_rdy_en = 1'b0;
        step();
        step();
        mul_rdy_en = 1'b1;
      end
      do_op(N'($urandom_range(1, 15)), int'($urandom_range(0, 3)), wc);
    end

    // Reset between clock edges while the multiplier is busy.
    randomize_ops();
    req_v_i = 4'b0100;
    #1;
    chk("midrst_grant", 128'(mul_v_o), 128'(1));
    step();
    #2;
    reset_i = 1'b1;
    #1;
    chk("midrst_req_ready", 128'(req_ready_o), 128'(0));
    chk("midrst_mul_v", 128'(mul_v_o), 128'(0));
    chk("midrst_mul_yumi", 128'(mul_yumi_o), 128'(0));
    chk("midrst_resp_v", 128'(resp_v_o), 128'(0));
    chk("midrst_ops_done", 128'(ops_done_o), 128'(0));
    step();
    reset_i = 1'b0;
    req_v_i = '0;
    model_reset();

    // Fairness from reset with all requesters active.
    for (int i = 0; i < 8; i++) begin
      randomize_ops();
      do_op('1, 0, wc);
    end
    if (order_q.size() >= 5) begin
      chk("fair_order0", 128'(order_q[0]), 128'd0);
      chk("fair_order1", 128'(order_q[1]), 128'd1);
      chk("fair_order2", 128'(order_q[2]), 128'd2);
      chk("fair_order3", 128'(order_q[3]), 128'd3);
      chk("fair_order4", 128'(order_q[4]), 128'd0);
    end else begin
      chk("fair_order_count", 128'(order_q.size()), 128'd8);
    end
    for (int i = 0; i < N; i++) chk("fair_count", 128'(grants[i]), 128'd2);
    chk("fair_ops_done", 128'(ops_done_o), 128'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_mul_iterative_scheduler.md
BSG_MUL_ITERATIVE_SCHEDULER -- requirements
Module: bsg_mul_iterative_scheduler

Interface
REQ-001 The block SHALL have parameter num_req_p, default 4, giving the requester count (2..16).
REQ-002 The block SHALL have parameter width_p, default 64, giving the operand width, matching the shared multiplier.
REQ-003 The block SHALL have ports clk_i (in, 1, clock) and reset_i (in, 1, reset); one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port req_v_i (in, num_req_p): per-requester operation valid.
REQ-005 The block SHALL have ports req_opA_i and req_opB_i (in, num_req_p x width_p): per-requester operands.
REQ-006 The block SHALL have port req_signed_i (in, num_req_p): per-requester signed-multiply select.
REQ-007 The block SHALL have port req_ready_o (out, num_req_p): one-hot grant; a request is accepted on req_v_i[i] & req_ready_o[i].
REQ-008 The block SHALL have ports mul_ready_i (in, 1), mul_v_o (out, 1), mul_opA_o and mul_opB_o (out, width_p), and mul_signed_o (out, 1), forming the multiplier issue channel.
REQ-009 The block SHALL have ports mul_v_i (in, 1), mul_result_i (in, 2*width_p) and mul_yumi_o (out, 1), forming the multiplier result channel.
REQ-010 The block SHALL have ports resp_v_o (out, num_req_p, one-hot), resp_data_o (out, 2*width_p) and resp_yumi_i (in, num_req_p), forming the response channel.
REQ-011 The block SHALL have port ops_done_o (out, 32): count of completed responses.

Function
REQ-012 States SHALL be eIdle, eBusy and eResp; every other encoding SHALL recover to eIdle.
REQ-013 In eIdle with mul_ready_i=1 and any req_v_i set, the block SHALL grant exactly one requester by round-robin: highest priority goes to (last_grant+1) mod num_req_p.
REQ-014 req_ready_o SHALL be all-zero outside eIdle and whenever mul_ready_i=0; it SHALL depend only on state, mul_ready_i, req_v_i and the priority pointer.
REQ-015 On the grant cycle the block SHALL assert mul_v_o and pass the granted requester's operands and signed bit unregistered to the mul_* outputs, SHALL record the owner index, SHALL update last_grant, and SHALL move to eBusy.
REQ-016 mul_v_o SHALL be 0 in eBusy and eResp.
REQ-017 In eBusy, on mul_v_i=1 the block SHALL assert mul_yumi_o in the same cycle, SHALL register mul_result_i, and SHALL move to eResp; mul_yumi_o SHALL be 0 in all other cases.
REQ-018 In eResp, resp_v_o SHALL be one-hot at the owner index and resp_data_o SHALL hold the registered result, stable until accepted.
REQ-019 In eResp, resp_yumi_i[owner]=1 SHALL move the block to eIdle and increment ops_done_o, which wraps modulo 2^32; resp_yumi_i bits for non-owners SHALL be ignored.
REQ-020 A new grant SHALL NOT occur in the cycle a response is accepted; the earliest next grant is the following cycle.
REQ-021 Issue-to-response latency SHALL be the multiplier latency plus 1 cycle; there is at most one operation in flight.
REQ-022 A requester that drops req_v_i before it is granted SHALL lose nothing; the pointer SHALL advance only on a grant.
REQ-023 When only one requester is active, it SHALL be granted on every eIdle cycle with mul_ready_i=1.

Reset
REQ-024 On reset assertion, the block SHALL go to eIdle immediately, independent of clk_i, including mid-operation.
REQ-025 Reset SHALL set last_grant to num_req_p-1 (requester 0 first), owner to 0, result register to 0 and ops_done_o to 0.
REQ-026 While reset is asserted, req_ready_o, mul_v_o, mul_yumi_o and resp_v_o SHALL all be 0; the multiplier SHALL share the same reset.

Structure
REQ-027 Package bsg_mul_sched_pkg SHALL hold the state enum typedef and the ops counter width constant (32).
REQ-028 The round-robin arbitration SHALL be one sub-module, bsg_mul_sched_rr_arb, with inputs reqs, enable and pointer and one-hot grant output; everything else SHALL be inline.

Verification
REQ-029 Single request: requester 2 issues opA=3, opB=5, unsigned -> resp_v_o=4'b0100 with resp_data_o=15 at multiplier latency+1; ops_done_o=1.
REQ-030 Signed request: requester 0 issues opA=-2, opB=3, signed -> resp_data_o=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA.
REQ-031 Fairness: all four requesters hold req_v_i continuously from reset -> grant order 0,1,2,3,0; each gets exactly one grant per 4 operations.
REQ-032 Backpressure: resp_yumi_i held 0 for 20 cycles -> resp_v_o and resp_data_o stay stable, req_ready_o=0 throughout, and no mul_v_o.
REQ-033 Reset mid-operation: reset_i asserted in eBusy between clock edges -> all outputs go to 0 asynchronously; after release, requester 0 is granted first and ops_done_o=0.
REQ-034 mul_ready_i=0 in eIdle with requests pending -> no grant and mul_v_o=0; when mul_ready_i rises, the grant occurs the same cycle.
